lsu_dcache_port_arbiter: RTL and testbench
==========================================

# lsu_dcache_port_arbiter

Shares one data-cache request port between the load unit, store unit and page-table walker of the load/store unit. It arbitrates with a locked round-robin scheme and holds the chosen request stable until the cache grants it. It also tracks outstanding reads in order so each read response is routed back to the requester that issued it. It sits between the LSU sub-units and the dcache request port, and supports flush-time discard of in-flight read responses.

## Interface
- NumPorts, 3, number of requesters (0 = PTW, 1 = load, 2 = store)
- AddrW, 64, request address width
- DataW, 64, data width; byte-enable width is DataW/8
- MaxOutstanding, 4, maximum granted-but-unanswered reads (power of two, ≥2)
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  discard responses to all reads outstanding at this edge
- req_i  in  NumPorts  per-requester request valid
- addr_i  in  NumPorts×AddrW  per-requester address
- we_i  in  NumPorts  per-requester write flag (1 = store, no response)
- wdata_i  in  NumPorts×DataW  per-requester write data
- be_i  in  NumPorts×DataW/8  per-requester byte enables
- gnt_o  out  NumPorts  one-hot grant back to requester
- rvalid_o  out  NumPorts  one-hot read-response valid
- rdata_o  out  DataW  read data, shared by all requesters
- cache_req_o  out  1  request to dcache
- cache_addr_o / cache_we_o / cache_wdata_o / cache_be_o  out  AddrW / 1 / DataW / DataW/8  selected request fields
- cache_gnt_i  in  1  dcache accepts request
- cache_rvalid_i  in  1  read response valid, in issue order
- cache_rdata_i  in  DataW  read response data
- busy_o  out  1  at least one read outstanding

## Operation
- FSM with two states: IDLE and WAIT_GNT.
- IDLE:
  - Pick the first eligible requester at or after rr_q, wrapping modulo NumPorts.
  - A requester is eligible if req_i is set and it is a write, or it is a read and outstanding count < MaxOutstanding.
  - Drive the cache port combinationally from the winner.
  - If cache_gnt_i is set the same cycle: pulse gnt_o[winner], advance rr_q to winner+1 (mod NumPorts), stay IDLE.
  - Otherwise latch the winner into sel_q and go to WAIT_GNT.
- WAIT_GNT:
  - The cache port is driven from sel_q only; there is no re-arbitration and newly raised requests are ignored.
  - Requesters hold req and fields stable until granted.
  - On cache_gnt_i: pulse gnt_o[sel_q], advance rr_q, return to IDLE.
- Read tracking:
  - Each granted read pushes its requester id into the order FIFO (depth MaxOutstanding) and increments the count.
  - Writes are not tracked.
- Response path:
  - On cache_rvalid_i with a non-empty FIFO, pop the head.
  - rvalid_o[head] = 1 unless the head entry is marked dropped; rdata_o = cache_rdata_i, passed combinationally.
- Flush:
  - flush_i marks every FIFO entry present at that edge as dropped. Their responses are consumed but not forwarded.
  - Reads granted in the same cycle as flush_i are also marked dropped.
  - The FSM state and the pending WAIT_GNT request are unaffected; a cache request is never withdrawn.
- Simultaneous push and pop: both take effect and the count is unchanged.
- A read is never granted when count == MaxOutstanding, even if a pop occurs that cycle.
- cache_rvalid_i with an empty FIFO is a protocol error: it is ignored and no rvalid_o is raised.
- busy_o = (count != 0).

## Timing
- Reset values: state IDLE, rr_q 0, sel_q 0, count 0, FIFO pointers 0, all drop marks 0.
- Output values during reset: gnt_o 0, rvalid_o 0, cache_req_o 0, busy_o 0.
- Best-case request-to-grant latency: 0 cycles (gnt_o in the same cycle as req_i when cache_gnt_i is set).
- gnt_o and rvalid_o are single-cycle pulses and at most one bit of each is set.
- The count update and the FIFO push/pop are registered; an eligibility change takes effect in the cycle after the edge.
- Fairness: with all requesters continuously active, each is granted once per NumPorts grants.
- Reset asserted mid-transaction clears all state immediately; responses arriving after release are dropped as a protocol error (empty FIFO).

## Test plan
- Single load read at addr 0x80, cache_gnt_i the same cycle, cache_rvalid_i 3 cycles later with 0xDEAD -> gnt_o = 3'b010 at cycle 0; rvalid_o = 3'b010 and rdata_o = 0xDEAD at cycle 3; busy_o high for cycles 1–3.
- All three ports requesting reads, cache_gnt_i always high -> grant order 0, 1, 2, 0, 1, 2; responses returned in that order with rvalid_o following the FIFO order.
- Store request with cache_gnt_i held low for 4 cycles while port 0 raises req -> cache_addr_o stays at the store address; gnt_o = 3'b100 on the 5th cycle; port 0 is granted next.
- Four load reads outstanding (MaxOutstanding = 4), load requests a fifth read while the store requests a write -> the store is granted and the load is blocked; after one rvalid the load is granted the following cycle.
- Two reads outstanding, flush_i pulsed, then a new PTW read granted, then three responses arrive -> the first two responses raise no rvalid_o; the third raises rvalid_o = 3'b001.
- rst_ni asserted while in WAIT_GNT with two reads outstanding -> cache_req_o and busy_o drop immediately; after release the first request arbitrates starting from port 0.

Source files
------------

// File: rtl/lsu_dcache_port_arbiter_if.sv
// Data-cache request port as seen from the LSU side.
// master: the arbiter, which drives requests and receives grant/response.
// slave: the dcache, which accepts requests and returns read data in issue order.
interface lsu_dcache_port_arbiter_if #(
   parameter int AddrW = 64,
   parameter int DataW = 64
);
   logic               req;
   logic [AddrW-1:0]   addr;
   logic               we;
   logic [DataW-1:0]   wdata;
   logic [DataW/8-1:0] be;
   logic               gnt;
   logic               rvalid;
   logic [DataW-1:0]   rdata;

   modport master (
      output req, addr, we, wdata, be,
      input  gnt, rvalid, rdata
   );

   modport slave (
      input  req, addr, we, wdata, be,
      output gnt, rvalid, rdata
   );
endinterface

// File: rtl/lsu_dcache_port_arbiter.sv
// Shares one dcache request port between PTW (0), load (1) and store (2).
// Locked round-robin arbitration: once a request is presented it is held until
// the cache grants it. Granted reads are tracked in an in-order FIFO so each
// response is steered back to its issuer; a flush marks in-flight reads as
// dropped so their responses are consumed silently.
module lsu_dcache_port_arbiter #(
   parameter int NumPorts       = 3,
   parameter int AddrW          = 64,
   parameter int DataW          = 64,
   parameter int MaxOutstanding = 4
) (
   input  logic                               clk_i,
   input  logic                               rst_ni,
   input  logic                               flush_i,
   input  logic [NumPorts-1:0]                req_i,
   input  logic [NumPorts-1:0][AddrW-1:0]     addr_i,
   input  logic [NumPorts-1:0]                we_i,
   input  logic [NumPorts-1:0][DataW-1:0]     wdata_i,
   input  logic [NumPorts-1:0][DataW/8-1:0]   be_i,
   output logic [NumPorts-1:0]                gnt_o,
   output logic [NumPorts-1:0]                rvalid_o,
   output logic [DataW-1:0]                   rdata_o,
   lsu_dcache_port_arbiter_if.master          cache,
   output logic                               busy_o
);

   localparam int IdW  = (NumPorts > 1) ? $clog2(NumPorts) : 1;
   localparam int PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
   localparam int CntW = PtrW + 1;

   typedef logic [IdW-1:0] id_t;
   typedef enum logic {IDLE, WAIT_GNT} state_t;

   state_t                  state_q;
   id_t                     rr_q;
   id_t                     sel_q;
   logic [CntW-1:0]         cnt_q;
   logic [CntW-1:0]         cnt_d;
   logic [PtrW-1:0]         wr_ptr_q;
   logic [PtrW-1:0]         rd_ptr_q;
   id_t                     fifo_id_q [MaxOutstanding];
   logic [MaxOutstanding-1:0] drop_q;

   logic                    room;
   logic [NumPorts-1:0]     elig;
   logic                    win_vld;
   id_t                     win_id;
   logic                    cur_vld;
   id_t                     cur_id;
   id_t                     rr_d;
   logic                    grant;
   logic                    push;
   logic                    pop;
   logic                    head_drop;
   id_t                     head_id;

   // A read may only be granted while the tracking FIFO has a free slot;
   // a pop in the same cycle does not free it early.
   assign room = (cnt_q != CntW'(MaxOutstanding));

   for (genvar gi = 0; gi < NumPorts; gi++) begin : g_elig
      assign elig[gi] = req_i[gi] & (we_i[gi] | room);
   end

   // Round-robin search: first eligible requester at or after rr_q.
   // Walking offsets downwards lets the smallest offset win.
   always_comb begin
      int  idx;
      id_t cand;
      win_vld = 1'b0;
      win_id  = '0;
      idx     = 0;
      cand    = '0;
      for (int k = NumPorts - 1; k >= 0; k--) begin
         idx = int'(rr_q) + k;
         if (idx >= NumPorts) begin
            idx = idx - NumPorts;
         end
         cand = id_t'(idx);
         if (elig[cand]) begin
            win_vld = 1'b1;
            win_id  = cand;
         end
      end
   end

   // In WAIT_GNT the port is locked to sel_q; new requests are not considered.
   assign cur_vld = (state_q == WAIT_GNT) ? 1'b1 : win_vld;
   assign cur_id  = (state_q == WAIT_GNT) ? sel_q : win_id;
   assign rr_d    = (cur_id == id_t'(NumPorts - 1)) ? '0 : cur_id + 1'b1;

   assign grant = cur_vld & cache.gnt;
   assign push  = grant & ~we_i[cur_id];
   assign pop   = cache.rvalid & (cnt_q != '0);

   // Outputs are forced quiet while reset is held even if requesters keep req high.
   assign cache.req   = rst_ni & cur_vld;
   assign cache.addr  = addr_i[cur_id];
   assign cache.we    = we_i[cur_id];
   assign cache.wdata = wdata_i[cur_id];
   assign cache.be    = be_i[cur_id];

   assign head_id   = fifo_id_q[rd_ptr_q];
   assign head_drop = drop_q[rd_ptr_q];

   for (genvar gi = 0; gi < NumPorts; gi++) begin : g_out
      assign gnt_o[gi]    = rst_ni & grant & (cur_id == id_t'(gi));
      assign rvalid_o[gi] = pop & ~head_drop & (head_id == id_t'(gi));
   end

   assign rdata_o = cache.rdata;
   assign busy_o  = (cnt_q != '0);

   // Outstanding-read count: simultaneous push and pop cancel out.
   always_comb begin
      cnt_d = cnt_q;
      if (push && !pop) begin
         cnt_d = cnt_q + 1'b1;
      end else if (!push && pop) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   // Arbitration FSM: latch an ungranted winner and hold it until accepted.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         rr_q    <= '0;
         sel_q   <= '0;
      end else begin
         if (grant) begin
            rr_q <= rr_d;
         end
         case (state_q)
            IDLE: begin
               if (win_vld && !cache.gnt) begin
                  sel_q   <= win_id;
                  state_q <= WAIT_GNT;
               end
            end
            WAIT_GNT: begin
               if (cache.gnt) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Read-order bookkeeping: count, pointers and per-slot drop marks.
   // A flush marks every slot; the slot written by a same-cycle push takes
   // the flush value, so free slots never carry a stale mark forward.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         drop_q   <= '0;
      end else begin
         cnt_q <= cnt_d;
         if (push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         if (flush_i) begin
            drop_q <= '1;
         end
         if (push) begin
            drop_q[wr_ptr_q] <= flush_i;
         end
      end
   end

   // Requester id storage; entries are only read while the count says valid.
   always_ff @(posedge clk_i) begin
      if (push) begin
         fifo_id_q[wr_ptr_q] <= cur_id;
      end
   end

endmodule

// File: tb/tb_lsu_dcache_port_arbiter.sv
// Directed bench for lsu_dcache_port_arbiter. Stimulus pushes the expected
// grant / response of each cycle into queues; a monitor on the falling edge
// pops and compares whenever the DUT grants or a cache response is consumed.
module tb_lsu_dcache_port_arbiter;

   localparam int NP = 3;
   localparam int AW = 64;
   localparam int DW = 64;

   typedef struct packed {
      logic [1:0]    id;
      logic [AW-1:0] addr;
      logic          we;
   } gnt_exp_t;

   typedef struct packed {
      logic [NP-1:0] rv;
      logic [DW-1:0] data;
   } rsp_exp_t;

   logic                        clk_i = 1'b0;
   logic                        rst_ni;
   logic                        flush_i;
   logic [NP-1:0]               req_i;
   logic [NP-1:0][AW-1:0]       addr_i;
   logic [NP-1:0]               we_i;
   logic [NP-1:0][DW-1:0]       wdata_i;
   logic [NP-1:0][DW/8-1:0]     be_i;
   logic [NP-1:0]               gnt_o;
   logic [NP-1:0]               rvalid_o;
   logic [DW-1:0]               rdata_o;
   logic                        busy_o;

   lsu_dcache_port_arbiter_if #(.AddrW(AW), .DataW(DW)) bus ();

   lsu_dcache_port_arbiter #(
      .NumPorts(NP), .AddrW(AW), .DataW(DW), .MaxOutstanding(4)
   ) dut (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .flush_i (flush_i),
      .req_i   (req_i),
      .addr_i  (addr_i),
      .we_i    (we_i),
      .wdata_i (wdata_i),
      .be_i    (be_i),
      .gnt_o   (gnt_o),
      .rvalid_o(rvalid_o),
      .rdata_o (rdata_o),
      .cache   (bus),
      .busy_o  (busy_o)
   );

   always #5 clk_i = ~clk_i;

   int vectors     = 0;
   int miscompares = 0;

   gnt_exp_t gq[$];
   rsp_exp_t rq[$];
   gnt_exp_t mg;
   rsp_exp_t mr;

   logic [AW-1:0] port_addr [NP];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic exp_g(input int id, input logic we);
      gnt_exp_t e;
      e.id   = 2'(id);
      e.addr = port_addr[id];
      e.we   = we;
      gq.push_back(e);
   endtask

   task automatic exp_r(input logic [NP-1:0] rv, input logic [DW-1:0] data);
      rsp_exp_t e;
      e.rv   = rv;
      e.data = data;
      rq.push_back(e);
   endtask

   // One cycle: drive just after the rising edge, return at the falling edge.
   task automatic cyc(input logic [NP-1:0] req, input logic [NP-1:0] we, input logic g,
                      input logic rv, input logic [DW-1:0] rd, input logic fl);
      @(posedge clk_i);
      #1;
      req_i      = req;
      we_i       = we;
      bus.gnt    = g;
      bus.rvalid = rv;
      bus.rdata  = rd;
      flush_i    = fl;
      @(negedge clk_i);
   endtask

   task automatic idle();
      cyc(3'b000, 3'b000, 1'b0, 1'b0, '0, 1'b0);
   endtask

   // Monitor: compare grants and consumed responses against the queues.
   always @(negedge clk_i) begin
      if (rst_ni) begin
         if (gnt_o != '0 || (bus.req && bus.gnt)) begin
            if (gq.size() == 0) begin
               chk("unexpected_gnt", 64'(gnt_o), 64'h0);
            end else begin
               mg = gq.pop_front();
               $display("grant: gnt_o=%b addr=0x%0h we=%0b (want port %0d)",
                        gnt_o, bus.addr, bus.we, mg.id);
               chk("gnt_o", 64'(gnt_o), 64'd1 << mg.id);
               chk("gnt_addr", bus.addr, mg.addr);
               chk("gnt_we", 64'(bus.we), 64'(mg.we));
            end
         end
         if (bus.rvalid) begin
            if (rq.size() == 0) begin
               chk("unexpected_rsp", 64'(rvalid_o), 64'h0);
            end else begin
               mr = rq.pop_front();
               $display("response: rvalid_o=%b rdata_o=0x%0h (want %b)", rvalid_o, rdata_o, mr.rv);
               chk("rvalid_o", 64'(rvalid_o), 64'(mr.rv));
               if (mr.rv != '0) begin
                  chk("rdata_o", rdata_o, mr.data);
               end
            end
         end else if (rvalid_o != '0) begin
            chk("spurious_rvalid", 64'(rvalid_o), 64'h0);
         end
      end
   end

   initial begin
      port_addr[0] = 64'h1000;
      port_addr[1] = 64'h80;
      port_addr[2] = 64'h2000;
      for (int i = 0; i < NP; i++) begin
         addr_i[i]  = port_addr[i];
         wdata_i[i] = 64'hCAFE_0000 + 64'(i);
         be_i[i]    = 8'hFF;
      end
      rst_ni     = 1'b0;
      flush_i    = 1'b0;
      req_i      = 3'b010;
      we_i       = 3'b000;
      bus.gnt    = 1'b1;
      bus.rvalid = 1'b0;
      bus.rdata  = '0;

      // Reset state with a request pending: outputs must stay quiet.
      #12;
      chk("rst_gnt_o", 64'(gnt_o), 64'h0);
      chk("rst_rvalid_o", 64'(rvalid_o), 64'h0);
      chk("rst_cache_req", 64'(bus.req), 64'h0);
      chk("rst_busy", 64'(busy_o), 64'h0);
      @(posedge clk_i);
      #1;
      rst_ni  = 1'b1;
      req_i   = '0;
      bus.gnt = 1'b0;

      // All three reading with the cache always ready: 0,1,2 then 0,1,2.
      for (int r = 0; r < 2; r++) begin
         for (int p = 0; p < NP; p++) begin
            exp_g(p, 1'b0);
            cyc(3'b111, 3'b000, 1'b1, 1'b0, '0, 1'b0);
         end
         for (int p = 0; p < NP; p++) begin
            exp_r(3'(1 << p), 64'hA0 + 64'(16 * r + p));
            cyc(3'b000, 3'b000, 1'b0, 1'b1, 64'hA0 + 64'(16 * r + p), 1'b0);
         end
      end
      idle();
      chk("rr_busy_drained", 64'(busy_o), 64'h0);

      // Single load at 0x80, zero-latency grant, response three cycles later.
      exp_g(1, 1'b0);
      cyc(3'b010, 3'b000, 1'b1, 1'b0, '0, 1'b0);
      chk("ld_busy_c0", 64'(busy_o), 64'h0);
      idle();
      chk("ld_busy_c1", 64'(busy_o), 64'h1);
      idle();
      chk("ld_busy_c2", 64'(busy_o), 64'h1);
      exp_r(3'b010, 64'hDEAD);
      cyc(3'b000, 3'b000, 1'b0, 1'b1, 64'hDEAD, 1'b0);
      chk("ld_busy_c3", 64'(busy_o), 64'h1);
      chk("ld_rdata", rdata_o, 64'hDEAD);
      idle();
      chk("ld_busy_c4", 64'(busy_o), 64'h0);

      // Store held by a slow cache while PTW raises a request (rr_q = 2).
      cyc(3'b100, 3'b100, 1'b0, 1'b0, '0, 1'b0);
      chk("st_cache_req", 64'(bus.req), 64'h1);
      chk("st_addr_c0", bus.addr, 64'h2000);
      for (int c = 1; c < 4; c++) begin
         cyc(3'b101, 3'b100, 1'b0, 1'b0, '0, 1'b0);
         chk("st_addr_hold", bus.addr, 64'h2000);
         chk("st_no_gnt", 64'(gnt_o), 64'h0);
      end
      exp_g(2, 1'b1);
      cyc(3'b101, 3'b100, 1'b1, 1'b0, '0, 1'b0);
      chk("st_gnt_c4", 64'(gnt_o), 64'h4);
      exp_g(0, 1'b0);
      cyc(3'b001, 3'b000, 1'b1, 1'b0, '0, 1'b0);
      chk("st_untracked", 64'(busy_o), 64'h0);
      exp_r(3'b001, 64'hC0);
      cyc(3'b000, 3'b000, 1'b0, 1'b1, 64'hC0, 1'b0);

      // Fill to four outstanding loads (rr_q = 1), then check blocking.
      for (int i = 0; i < 4; i++) begin
         exp_g(1, 1'b0);
         cyc(3'b010, 3'b000, 1'b1, 1'b0, '0, 1'b0);
      end
      cyc(3'b010, 3'b000, 1'b1, 1'b0, '0, 1'b0);
      chk("full_ld_blocked", 64'(gnt_o), 64'h0);
      chk("full_no_req", 64'(bus.req), 64'h0);
      exp_g(2, 1'b1);
      cyc(3'b110, 3'b100, 1'b1, 1'b0, '0, 1'b0);
      exp_r(3'b010, 64'hD0);
      cyc(3'b010, 3'b000, 1'b1, 1'b1, 64'hD0, 1'b0);
      chk("full_pop_still_blocked", 64'(gnt_o), 64'h0);
      exp_g(1, 1'b0);
      cyc(3'b010, 3'b000, 1'b1, 1'b0, '0, 1'b0);
      chk("full_ld_after_pop", 64'(gnt_o), 64'h2);
      for (int i = 1; i <= 4; i++) begin
         exp_r(3'b010, 64'hD0 + 64'(i));
         cyc(3'b000, 3'b000, 1'b0, 1'b1, 64'hD0 + 64'(i), 1'b0);
      end

      // Flush with two reads in flight (rr_q = 2).
      exp_g(0, 1'b0);
      cyc(3'b001, 3'b000, 1'b1, 1'b0, '0, 1'b0);
      exp_g(1, 1'b0);
      cyc(3'b010, 3'b000, 1'b1, 1'b0, '0, 1'b0);
      cyc(3'b000, 3'b000, 1'b0, 1'b0, '0, 1'b1);
      chk("fl_busy", 64'(busy_o), 64'h1);
      exp_g(0, 1'b0);
      cyc(3'b001, 3'b000, 1'b1, 1'b0, '0, 1'b0);
      exp_r(3'b000, 64'hE0);
      cyc(3'b000, 3'b000, 1'b0, 1'b1, 64'hE0, 1'b0);
      exp_r(3'b000, 64'hE1);
      cyc(3'b000, 3'b000, 1'b0, 1'b1, 64'hE1, 1'b0);
      exp_r(3'b001, 64'hE2);
      cyc(3'b000, 3'b000, 1'b0, 1'b1, 64'hE2, 1'b0);
      // A read granted in the flush cycle is dropped too (rr_q = 1).
      exp_g(1, 1'b0);
      cyc(3'b010, 3'b000, 1'b1, 1'b0, '0, 1'b1);
      exp_r(3'b000, 64'hF0);
      cyc(3'b000, 3'b000, 1'b0, 1'b1, 64'hF0, 1'b0);
      idle();
      chk("fl_busy_drained", 64'(busy_o), 64'h0);

      // Reset in WAIT_GNT with two reads outstanding (rr_q = 2).
      exp_g(0, 1'b0);
      cyc(3'b001, 3'b000, 1'b1, 1'b0, '0, 1'b0);
      exp_g(1, 1'b0);
      cyc(3'b010, 3'b000, 1'b1, 1'b0, '0, 1'b0);
      cyc(3'b100, 3'b000, 1'b0, 1'b0, '0, 1'b0);
      chk("rw_cache_req", 64'(bus.req), 64'h1);
      chk("rw_busy", 64'(busy_o), 64'h1);
      @(posedge clk_i);
      #1;
      rst_ni = 1'b0;
      #1;
      chk("rw_req_dropped", 64'(bus.req), 64'h0);
      chk("rw_busy_dropped", 64'(busy_o), 64'h0);
      @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      req_i  = '0;
      exp_r(3'b000, 64'h11);
      cyc(3'b000, 3'b000, 1'b0, 1'b1, 64'h11, 1'b0);
      exp_r(3'b000, 64'h22);
      cyc(3'b000, 3'b000, 1'b0, 1'b1, 64'h22, 1'b0);
      exp_g(0, 1'b0);
      cyc(3'b111, 3'b000, 1'b1, 1'b0, '0, 1'b0);
      chk("rw_restart_port0", 64'(gnt_o), 64'h1);
      idle();
      exp_r(3'b001, 64'h33);
      cyc(3'b000, 3'b000, 1'b0, 1'b1, 64'h33, 1'b0);
      idle();
      idle();

      chk("grant_queue_empty", 64'(gq.size()), 64'h0);
      chk("response_queue_empty", 64'(rq.size()), 64'h0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
